// File: rtl/dtg_vga.sv
// 640x480@60Hz VGA display timing generator: pixel tick divider, row/column counters, delayed sync/blank.
// Optional macro DTG_FRAME_TICK_EN adds a frame_tick pulse on the end-of-frame wrap.
module dtg_vga #(
   parameter int CLK_DIV    = 4,
   parameter int H_VISIBLE  = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_POL   = 0,
   parameter int SYNC_DELAY = 1
) (
   input  logic       clk,
   input  logic       reset,
   output logic       pix_en,
   output logic [9:0] pixel_column,
   output logic [9:0] pixel_row,
   output logic       horiz_sync,
   output logic       vert_sync,
   output logic       video_on
`ifdef DTG_FRAME_TICK_EN
   ,
   output logic       frame_tick
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic       ACT_LVL  = 1'(SYNC_POL);

   logic [3:0] div;
   logic       div_last;
   logic       hs_raw;
   logic       vs_raw;
   logic       von_raw;
   logic [2:0] raw_bus;
   logic [2:0] act;

   assign div_last = (div == DIV_LAST);

   // pix_en is registered from the terminal count, so it lands on the CLK_DIV-th edge after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div    <= '0;
         pix_en <= 1'b0;
      end else begin
         div    <= div_last ? 4'd0 : div + 4'd1;
         pix_en <= div_last;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel_column <= '0;
         pixel_row    <= '0;
      end else if (pix_en) begin
         if (pixel_column == H_LAST) begin
            pixel_column <= '0;
            pixel_row    <= (pixel_row == V_LAST) ? 10'd0 : pixel_row + 10'd1;
         end else begin
            pixel_column <= pixel_column + 10'd1;
         end
      end
   end

   assign hs_raw  = (pixel_column >= HS_START) && (pixel_column < HS_END);
   assign vs_raw  = (pixel_row >= VS_START) && (pixel_row < VS_END);
   assign von_raw = (pixel_column < H_VIS) && (pixel_row < V_VIS);
   assign raw_bus = {hs_raw, vs_raw, von_raw};

   // Without delay stages, reset must still force the outputs inactive since counters read (0,0).
   generate
      if (SYNC_DELAY == 0) begin : g_nodelay
         assign act = reset ? 3'b000 : raw_bus;
      end else begin : g_delay
         logic [SYNC_DELAY-1:0][2:0] stage;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               stage <= '0;
            end else if (pix_en) begin
               stage[0] <= raw_bus;
               for (int i = 1; i < SYNC_DELAY; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign act = stage[SYNC_DELAY-1];
      end
   endgenerate

   assign horiz_sync = act[2] ? ACT_LVL : ~ACT_LVL;
   assign vert_sync  = act[1] ? ACT_LVL : ~ACT_LVL;
   assign video_on   = act[0];

`ifdef DTG_FRAME_TICK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= div_last && (pixel_column == H_LAST) && (pixel_row == V_LAST);
      end
   end
`endif

endmodule

// File: tb/tb_dtg_vga.sv
// Self-checking bench for dtg_vga: three instances (default, zero delay, small fast config) against a scoreboard.
module tb_dtg_vga;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic       a_pe, a_hs, a_vs, a_von, a_ft;
   logic       b_pe, b_hs, b_vs, b_von, b_ft;
   logic       c_pe, c_hs, c_vs, c_von, c_ft;
   logic [9:0] a_col, a_row, b_col, b_row, c_col, c_row;

   int vectors = 0;
   int miscompares = 0;

   dtg_vga u_a (
      .clk(clk), .reset(reset), .pix_en(a_pe), .pixel_column(a_col), .pixel_row(a_row),
      .horiz_sync(a_hs), .vert_sync(a_vs), .video_on(a_von)
`ifdef DTG_FRAME_TICK_EN
      , .frame_tick(a_ft)
`endif
   );

   dtg_vga #(.SYNC_DELAY(0)) u_b (
      .clk(clk), .reset(reset), .pix_en(b_pe), .pixel_column(b_col), .pixel_row(b_row),
      .horiz_sync(b_hs), .vert_sync(b_vs), .video_on(b_von)
`ifdef DTG_FRAME_TICK_EN
      , .frame_tick(b_ft)
`endif
   );

   dtg_vga #(.CLK_DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_VISIBLE(8), .V_FP(1),
             .V_SYNC(2), .V_BP(2), .SYNC_POL(1), .SYNC_DELAY(3)) u_c (
      .clk(clk), .reset(reset), .pix_en(c_pe), .pixel_column(c_col), .pixel_row(c_row),
      .horiz_sync(c_hs), .vert_sync(c_vs), .video_on(c_von)
`ifdef DTG_FRAME_TICK_EN
      , .frame_tick(c_ft)
`endif
   );

`ifndef DTG_FRAME_TICK_EN
   assign a_ft = 1'b0;
   assign b_ft = 1'b0;
   assign c_ft = 1'b0;
`endif

   typedef struct {
      int cd; int hvis; int hfp; int hsync; int hbp;
      int vvis; int vfp; int vsync; int vbp; int pol; int dly;
   } cfg_t;

   typedef struct {
      int               div;
      logic             pe;
      int               col;
      int               row;
      logic             ft;
      logic [3:0][2:0]  dl;
   } ms_t;

   typedef logic [2:0][24:0] exp_t;

   ms_t  m [3];
   exp_t sb_q [$];

   logic [24:0] obs_a, obs_b, obs_c;
   assign obs_a = {a_ft, a_pe, a_row, a_col, a_hs, a_vs, a_von};
   assign obs_b = {b_ft, b_pe, b_row, b_col, b_hs, b_vs, b_von};
   assign obs_c = {c_ft, c_pe, c_row, c_col, c_hs, c_vs, c_von};

   function automatic cfg_t get_cfg(input int k);
      cfg_t c;
      c = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1};
      if (k == 1) c.dly = 0;
      if (k == 2) c = '{2, 16, 2, 4, 3, 8, 1, 2, 2, 1, 3};
      return c;
   endfunction

   function automatic logic [2:0] raw_dec(input cfg_t c, input int col, input int row);
      logic hs, vs, von;
      hs  = (col >= c.hvis + c.hfp) && (col < c.hvis + c.hfp + c.hsync);
      vs  = (row >= c.vvis + c.vfp) && (row < c.vvis + c.vfp + c.vsync);
      von = (col < c.hvis) && (row < c.vvis);
      return {hs, vs, von};
   endfunction

   function automatic ms_t reset_state();
      ms_t s;
      s.div = 0; s.pe = 1'b0; s.col = 0; s.row = 0; s.ft = 1'b0; s.dl = '0;
      return s;
   endfunction

   function automatic ms_t step(input cfg_t c, input ms_t s);
      ms_t  n;
      int   htot, vtot;
      logic last;
      htot = c.hvis + c.hfp + c.hsync + c.hbp;
      vtot = c.vvis + c.vfp + c.vsync + c.vbp;
      n    = s;
      last = (s.div == c.cd - 1);
      n.div = last ? 0 : s.div + 1;
      n.pe  = last;
      n.ft  = last && (s.col == htot - 1) && (s.row == vtot - 1);
      if (s.pe) begin
         n.dl = {s.dl[2:0], raw_dec(c, s.col, s.row)};
         if (s.col == htot - 1) begin
            n.col = 0;
            n.row = (s.row == vtot - 1) ? 0 : s.row + 1;
         end else begin
            n.col = s.col + 1;
         end
      end
      return n;
   endfunction

   function automatic logic [24:0] exp_vec(input cfg_t c, input ms_t s, input logic rst);
      logic [2:0] act;
      logic       p, ft;
      p = c.pol[0];
      if (c.dly == 0) act = rst ? 3'b000 : raw_dec(c, s.col, s.row);
      else            act = s.dl[c.dly-1];
`ifdef DTG_FRAME_TICK_EN
      ft = s.ft;
`else
      ft = 1'b0;
`endif
      return {ft, s.pe, s.row[9:0], s.col[9:0], act[2] ? p : ~p, act[1] ? p : ~p, act[0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
      end
   endtask

   // Reference model advances on every clock (or resets asynchronously) and queues what the DUTs should show.
   always @(posedge clk or posedge reset) begin : model_upd
      exp_t e;
      ms_t  nx;
      if (reset) sb_q.delete();
      for (int k = 0; k < 3; k++) begin
         nx   = reset ? reset_state() : step(get_cfg(k), m[k]);
         m[k] <= nx;
         e[k] = exp_vec(get_cfg(k), nx, reset);
      end
      sb_q.push_back(e);
   end

   always @(negedge clk) begin : sb_check
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checkOutput("sb_a", {7'b0, obs_a}, {7'b0, e[0]});
         checkOutput("sb_b", {7'b0, obs_b}, {7'b0, e[1]});
         checkOutput("sb_c", {7'b0, obs_c}, {7'b0, e[2]});
      end
   end

   task automatic wait_tick(input int which, output int clks);
      logic pe;
      clks = 0;
      do begin
         @(negedge clk);
         clks++;
         pe = (which == 2) ? c_pe : a_pe;
      end while (!pe && clks < 40);
      if (!pe) checkOutput("tick_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_c_at(input int row, input int col);
      int n = 0;
      while (!(c_pe && c_row == 10'(row) && c_col == 10'(col)) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput($sformatf("c_reach_%0d_%0d", row, col), {22'b0, c_row, c_col}, {22'b0, 10'(row), 10'(col)});
   endtask

   task automatic applyStimulus(input int hold_clks);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      checkOutput("rst_a_cnt", {12'b0, a_row, a_col}, 32'd0);
      checkOutput("rst_a_out", {28'b0, a_pe, a_hs, a_vs, a_von}, 32'b0110);
      checkOutput("rst_b_out", {28'b0, b_pe, b_hs, b_vs, b_von}, 32'b0110);
      checkOutput("rst_c_cnt", {12'b0, c_row, c_col}, 32'd0);
      checkOutput("rst_c_out", {27'b0, c_ft, c_pe, c_hs, c_vs, c_von}, 32'b0);
      repeat (hold_clks) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_hold_c", {12'b0, c_row, c_col}, 32'd0);
      #1 reset = 1'b0;
   endtask

   // One full small-config frame starting from the (0,0) tick.
   task automatic run_frame_c(input string tag);
      int clks, vs_cnt, von_cnt, ft_cnt, ft_idx;
      vs_cnt = 0; von_cnt = 0; ft_cnt = 0; ft_idx = -1;
      for (int k = 0; k < 325; k++) begin
         if (k > 0) wait_tick(2, clks);
         if (c_vs)  vs_cnt++;
         if (c_von) von_cnt++;
         if (c_ft) begin ft_cnt++; ft_idx = k; end
      end
      wait_tick(2, clks);
      checkOutput({tag, "_wrap"}, {12'b0, c_row, c_col}, 32'd0);
      checkOutput({tag, "_vs_ticks"}, vs_cnt, 32'd50);
      checkOutput({tag, "_von_ticks"}, von_cnt, 32'd128);
`ifdef DTG_FRAME_TICK_EN
      checkOutput({tag, "_ft_cnt"}, ft_cnt, 32'd1);
      checkOutput({tag, "_ft_idx"}, ft_idx, 32'd324);
`endif
   endtask

   initial begin
      int clks, n, hs_low, first_low, von_a, von_b, first_a, last_a;
      #2;
      applyStimulus(3);

      n = 0;
      do begin @(negedge clk); n++; end while (!a_pe && n < 20);
      checkOutput("first_pe_clks", n, 32'd4);
      checkOutput("first_tick_pos", {12'b0, b_row, b_col}, 32'd0);

      hs_low = 0; first_low = -1; von_a = 0; von_b = 0; first_a = -1; last_a = -1;
      for (int k = 0; k < 800; k++) begin
         if (k > 0) begin
            wait_tick(0, clks);
            if (k == 1) checkOutput("pe_period", clks, 32'd4);
         end
         if (!b_hs) begin hs_low++; if (first_low < 0) first_low = int'(b_col); end
         if (b_von) von_b++;
         if (a_von) begin von_a++; if (first_a < 0) first_a = k; last_a = k; end
      end
      wait_tick(0, clks);
      checkOutput("line_wrap", {12'b0, b_row, b_col}, {12'b0, 10'd1, 10'd0});
      checkOutput("hs_low_ticks", hs_low, 32'd96);
      checkOutput("hs_first_col", first_low, 32'd656);
      checkOutput("von_b_ticks", von_b, 32'd640);
      checkOutput("von_a_ticks", von_a, 32'd640);
      checkOutput("von_a_rise", first_a, 32'd1);
      checkOutput("von_a_last", last_a, 32'd640);

      wait_c_at(0, 0);
      run_frame_c("f1");

      wait_c_at(6, 10);
      applyStimulus(3);
      wait_tick(2, clks);
      checkOutput("c_first_pe_clks", clks, 32'd2);
      checkOutput("c_restart_pos", {12'b0, c_row, c_col}, 32'd0);
      run_frame_c("f2");

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dtg_vga.md
Name: dtg_vga

Overview:
- Display timing generator for the 640x480@60Hz VGA path on the Nexys4 board.
- Sits directly upstream of the bot world-map block:
  - pixel_row and pixel_column drive bot's vid_row and vid_col.
  - The delayed sync and blank outputs are aligned to bot's registered vid_pixel_out, which feeds the downstream colorizer and VGA pins.
- Derives a 25 MHz pixel tick from the 100 MHz system clock. All state is clocked on clk.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (legal 2..16).
- H_VISIBLE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, active sync level (0 = active-low).
- SYNC_DELAY, 1, pixel ticks of delay applied to sync and video_on relative to row/column (legal 0..3).

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- pix_en  out  1  one-clk pulse per pixel tick.
- pixel_column  out  10  horizontal counter, 0..H_TOTAL-1.
- pixel_row  out  10  vertical counter, 0..V_TOTAL-1.
- horiz_sync  out  1  horizontal sync, delayed.
- vert_sync  out  1  vertical sync, delayed.
- video_on  out  1  high in the visible region, delayed.

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Reset (asynchronous, active-high): divider, pixel_column and pixel_row = 0; pix_en = 0; video_on = 0; horiz_sync and vert_sync = ~SYNC_POL (inactive). All delay-stage registers take the same inactive values.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and high for exactly one clk when the divider equals CLK_DIV-1.
  - First pix_en is on the CLK_DIV-th rising edge after reset deasserts.
- Counters advance only in a cycle with pix_en = 1:
  - pixel_column increments; at H_TOTAL-1 it wraps to 0 and pixel_row increments.
  - pixel_row wraps to 0 when it is V_TOTAL-1 and pixel_column wraps, which starts a new frame.
  - Counters never exceed the TOTAL-1 values.
- Raw decode, combinational from the counters:
  - hs_raw is active when H_VISIBLE+H_FP <= col < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs_raw is active when V_VISIBLE+V_FP <= row < V_VISIBLE+V_FP+V_SYNC (490..491).
  - von_raw = (col < H_VISIBLE) && (row < V_VISIBLE).
- Delay line:
  - SYNC_DELAY stages, each loaded only on pix_en.
  - Outputs follow the counters they were decoded from by exactly SYNC_DELAY pixel ticks.
  - SYNC_DELAY = 0 drives outputs directly from the raw decode.
- Polarity: sync outputs equal SYNC_POL when active and ~SYNC_POL otherwise.
- Reset mid-frame: all state returns to reset values immediately, and the next frame starts cleanly from (0,0) with no partial sync pulse.
- pixel_row and pixel_column are not gated by video_on. Downstream uses video_on to blank.

Optional Feature:
- Macro: DTG_FRAME_TICK_EN.
- When defined:
  - Adds output port frame_tick (1 bit, reset 0).
  - frame_tick is a one-clk pulse in the same clk as the pix_en on which the counters wrap from (V_TOTAL-1, H_TOTAL-1) to (0,0).
  - nexys4_bot_if uses it as the upd_sysregs source.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: assert reset mid-run, then release. Required: outputs at reset values immediately; first pix_en on the 4th clk; period exactly 4 clks thereafter.
- Horizontal timing, SYNC_DELAY = 0. Required:
  - horiz_sync low for exactly 96 pix_en ticks, starting when pixel_column = 656.
  - video_on high for columns 0..639 of row 0.
  - Line length is 800 ticks.
- Line and frame wrap. Required:
  - pixel_column goes 799 -> 0 with pixel_row incrementing.
  - At (524,799) the next tick gives (0,0).
  - vert_sync is low for rows 490..491 only, which is 1600 ticks.
- Delay alignment, SYNC_DELAY = 1. Required: video_on rises one pix_en after pixel_column reaches 0 on row 0, and falls one tick after column 640.
- Mid-frame reset at row 300, col 400, held for 3 clks. Required: counters read 0,0 and syncs are high during reset; a full 525x800 frame follows.
- DTG_FRAME_TICK_EN defined. Required: exactly one frame_tick per 420000 pix_en ticks, coincident with the (0,0) wrap; no frame_tick during reset.
